// File: rtl/uart_tx_fast.sv
// UART transmitter with a fixed 3-clock bit period, one shift register and a
// one-entry holding buffer so that consecutive frames go out with no idle gap.
module uart_tx_fast #(
   parameter int    DATA_WIDTH   = 8,
   parameter string PARITY_CHECK = "NONE",
   parameter int    CLK_FREQ     = 240000000,
   parameter int    BAUD_RATE    = 80000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_rdy,
   output logic                  tx,
   output logic                  o_busy
);

   localparam int DIV     = CLK_FREQ / BAUD_RATE;
   localparam bit PAR_EN  = (PARITY_CHECK != "NONE");
   localparam bit PAR_ODD = (PARITY_CHECK == "ODD");
   localparam int IW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [1:0]    CNT_LAST = 2'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   if (PARITY_CHECK != "NONE" && PARITY_CHECK != "EVEN" && PARITY_CHECK != "ODD") begin : g_bad_parity
      $fatal(1, "uart_tx_fast: PARITY_CHECK must be NONE, EVEN or ODD");
   end
   if (DIV != 3) begin : g_bad_div
      $fatal(1, "uart_tx_fast: CLK_FREQ/BAUD_RATE must equal 3");
   end
   if (DATA_WIDTH < 2) begin : g_bad_width
      $fatal(1, "uart_tx_fast: DATA_WIDTH must be at least 2");
   end
   if (DATA_WIDTH > 8) begin : g_wide_width
      $warning("uart_tx_fast: DATA_WIDTH above 8 is non-standard");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state, state_nx;
   logic [1:0]              cnt, cnt_nx;
   logic [IW-1:0]           idx, idx_nx;
   logic                    tx_q, tx_nx;
   logic                    buf_vld, buf_vld_nx;
   logic                    alive;
   logic [DATA_WIDTH-1:0]   sh, hold;
   logic                    par_bit, hold_par;
   logic                    accept, bit_end;
   logic                    load_new, load_buf, shift_en, fill_buf;

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
      return (^word) ^ PAR_ODD;
   endfunction

   assign o_rdy  = alive & ~buf_vld;
   assign accept = i_vld & o_rdy;
   assign tx     = tx_q;
   assign o_busy = (state != IDLE);

   // tx_nx is the line value for the cycle that follows the coming edge, so
   // every state change and its bit appear on tx together.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      idx_nx     = idx;
      tx_nx      = tx_q;
      buf_vld_nx = buf_vld;
      load_new   = 1'b0;
      load_buf   = 1'b0;
      shift_en   = 1'b0;
      fill_buf   = 1'b0;
      bit_end    = (cnt == CNT_LAST);

      if (state != IDLE) begin
         cnt_nx = bit_end ? 2'd0 : cnt + 2'd1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               load_new = 1'b1;
               state_nx = START;
               cnt_nx   = 2'd0;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
               idx_nx   = '0;
               tx_nx    = sh[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx == IDX_LAST) begin
                  state_nx = PAR_EN ? PARITY : STOP;
                  tx_nx    = PAR_EN ? par_bit : 1'b1;
               end else begin
                  shift_en = 1'b1;
                  idx_nx   = idx + IDX_ONE;
                  tx_nx    = sh[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nx = STOP;
               tx_nx    = 1'b1;
            end
         end
         STOP: begin
            // A word arriving on the very last stop cycle goes straight into
            // the shift register; otherwise it would sit in the buffer while idle.
            if (bit_end) begin
               if (buf_vld) begin
                  load_buf   = 1'b1;
                  buf_vld_nx = 1'b0;
                  state_nx   = START;
                  tx_nx      = 1'b0;
               end else if (accept) begin
                  load_new = 1'b1;
                  state_nx = START;
                  tx_nx    = 1'b0;
               end else begin
                  state_nx = IDLE;
                  tx_nx    = 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase

      if (accept && !load_new) begin
         fill_buf   = 1'b1;
         buf_vld_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         idx     <= '0;
         tx_q    <= 1'b1;
         buf_vld <= 1'b0;
         alive   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         idx     <= idx_nx;
         tx_q    <= tx_nx;
         buf_vld <= buf_vld_nx;
         alive   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load_new) begin
         sh      <= i_data;
         par_bit <= parity_of(i_data);
      end else if (load_buf) begin
         sh      <= hold;
         par_bit <= hold_par;
      end else if (shift_en) begin
         sh      <= sh >> 1;
      end
      if (fill_buf) begin
         hold     <= i_data;
         hold_par <= parity_of(i_data);
      end
   end

endmodule

// File: tb/tb_uart_tx_fast.sv
// Bench for uart_tx_fast: NONE/EVEN/ODD instances, directed frames, back-to-back
// traffic, held-valid and randomized traffic decoded by a line receiver model.
module tb_uart_tx_fast;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       none_vld = 1'b0;
   logic [7:0] none_data = 8'h00;
   logic       none_rdy, none_tx, none_busy;
   logic       par_vld = 1'b0;
   logic [7:0] par_data = 8'h00;
   logic       even_rdy, even_tx, even_busy;
   logic       odd_rdy, odd_tx, odd_busy;

   int vectors = 0;
   int miscompares = 0;

   logic       rx_en = 1'b0;
   logic [7:0] rx_q[$];
   logic       stop_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_fast #(.DATA_WIDTH(8), .PARITY_CHECK("NONE"), .CLK_FREQ(240000000), .BAUD_RATE(80000000)) u_none (
      .clk(clk), .rst_n(rst_n), .i_vld(none_vld), .i_data(none_data),
      .o_rdy(none_rdy), .tx(none_tx), .o_busy(none_busy));

   uart_tx_fast #(.DATA_WIDTH(8), .PARITY_CHECK("EVEN"), .CLK_FREQ(240000000), .BAUD_RATE(80000000)) u_even (
      .clk(clk), .rst_n(rst_n), .i_vld(par_vld), .i_data(par_data),
      .o_rdy(even_rdy), .tx(even_tx), .o_busy(even_busy));

   uart_tx_fast #(.DATA_WIDTH(8), .PARITY_CHECK("ODD"), .CLK_FREQ(240000000), .BAUD_RATE(80000000)) u_odd (
      .clk(clk), .rst_n(rst_n), .i_vld(par_vld), .i_data(par_data),
      .o_rdy(odd_rdy), .tx(odd_tx), .o_busy(odd_busy));

   // Frame position idx: 0 start, 1..8 data LSB first, 9 parity (if any), last stop.
   function automatic logic exp_bit(input logic [7:0] w, input int mode, input int idx);
      int ones;
      ones = $countones(w);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      if (mode == 1 && idx == 9) return (ones % 2) == 1;
      if (mode == 2 && idx == 9) return (ones % 2) == 0;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic accept_none(input logic [7:0] w);
      int guard;
      guard = 0;
      none_vld = 1'b1;
      none_data = w;
      while (none_rdy !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("none_rdy_wait", {31'b0, none_rdy}, 32'd1);
      @(posedge clk); #1;
      none_vld = 1'b0;
   endtask

   task automatic check_none_frame(input logic [7:0] w, input string tag);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check({tag, "_tx"}, {31'b0, none_tx}, {31'b0, exp_bit(w, 0, k / 3)});
         check({tag, "_busy"}, {31'b0, none_busy}, 32'd1);
      end
      @(negedge clk);
      check({tag, "_end_tx"}, {31'b0, none_tx}, 32'd1);
      check({tag, "_end_busy"}, {31'b0, none_busy}, 32'd0);
   endtask

   task automatic send_par_frame(input logic [7:0] w);
      int guard;
      guard = 0;
      par_vld = 1'b1;
      par_data = w;
      while (!(even_rdy === 1'b1 && odd_rdy === 1'b1) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("par_rdy_wait", {30'b0, even_rdy, odd_rdy}, 32'd3);
      @(posedge clk); #1;
      par_vld = 1'b0;
      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         check("even_tx", {31'b0, even_tx}, {31'b0, exp_bit(w, 1, k / 3)});
         check("odd_tx", {31'b0, odd_tx}, {31'b0, exp_bit(w, 2, k / 3)});
         check("par_busy", {30'b0, even_busy, odd_busy}, 32'd3);
      end
      @(negedge clk);
      check("par_end", {28'b0, even_tx, odd_tx, even_busy, odd_busy}, 32'b1100);
   endtask

   // Line receiver: samples the middle of each 3-cycle bit on the NONE instance.
   initial begin
      logic [7:0] w;
      w = 8'h00;
      forever begin
         @(negedge clk);
         if (rx_en && none_tx === 1'b0) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (3) @(negedge clk);
               w[b] = none_tx;
            end
            repeat (3) @(negedge clk);
            stop_q.push_back(none_tx);
            rx_q.push_back(w);
         end
      end
   end

   initial begin
      logic [9:0] a5_frame;
      int guard;
      a5_frame = 10'b11_0100_1010;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_none", {29'b0, none_tx, none_busy, none_rdy}, 32'b100);
      check("rst_even", {29'b0, even_tx, even_busy, even_rdy}, 32'b100);
      check("rst_odd", {29'b0, odd_tx, odd_busy, odd_rdy}, 32'b100);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_before_edge", {31'b0, none_rdy}, 32'd0);
      @(negedge clk);
      check("rdy_after_edge", {29'b0, none_rdy, even_rdy, odd_rdy}, 32'b111);

      // Single 0xA5 frame against the literal line sequence
      accept_none(8'hA5);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check("a5_tx", {31'b0, none_tx}, {31'b0, a5_frame[k / 3]});
         check("a5_busy", {31'b0, none_busy}, 32'd1);
      end
      @(negedge clk);
      check("a5_idle", {29'b0, none_tx, none_busy, none_rdy}, 32'b101);

      // Parity frames
      send_par_frame(8'h07);
      for (int i = 0; i < 3; i++) send_par_frame(8'($urandom));

      // Back-to-back 0x55 then 0xAA with valid held high
      none_vld = 1'b1;
      none_data = 8'h55;
      @(posedge clk); #1;
      none_data = 8'hAA;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         check("b2b_tx", {31'b0, none_tx},
               {31'b0, (k < 30) ? exp_bit(8'h55, 0, k / 3) : exp_bit(8'hAA, 0, (k - 30) / 3)});
         check("b2b_busy", {31'b0, none_busy}, 32'd1);
         check("b2b_rdy", {31'b0, none_rdy}, (k >= 1 && k < 30) ? 32'd0 : 32'd1);
         if (k == 0) begin
            @(posedge clk); #1;
            none_vld = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_idle", {30'b0, none_tx, none_busy}, 32'b10);

      // Held valid with 0x3C, then randomized traffic, decoded from the line
      rx_q.delete(); stop_q.delete(); exp_q.delete();
      rx_en = 1'b1;
      @(posedge clk); #1;
      none_vld = 1'b1;
      none_data = 8'h3C;
      for (int c = 0; c < 40; c++) begin
         if (none_rdy === 1'b1) exp_q.push_back(none_data);
         @(posedge clk); #1;
      end
      for (int c = 0; c < 800; c++) begin
         none_vld = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 85 : 6));
         none_data = 8'($urandom);
         if (none_vld && none_rdy === 1'b1) exp_q.push_back(none_data);
         @(posedge clk); #1;
      end
      none_vld = 1'b0;
      guard = 0;
      while (none_busy !== 1'b0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_busy", {31'b0, none_busy}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      rx_en = 1'b0;
      check("rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         check("rx_word", {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
         check("rx_stop", {31'b0, stop_q[i]}, 32'd1);
      end

      // Reset mid-frame with a word in the holding buffer
      accept_none(8'hA5);
      none_vld = 1'b1;
      none_data = 8'h5A;
      @(posedge clk); #1;
      none_vld = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("pre_rst_busy", {31'b0, none_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_now", {29'b0, none_tx, none_busy, none_rdy}, 32'b100);
      repeat (2) @(posedge clk);
      #1;
      check("abort_hold", {29'b0, none_tx, none_busy, none_rdy}, 32'b100);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rdy0", {31'b0, none_rdy}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rel_idle", {29'b0, none_tx, none_busy, none_rdy}, 32'b101);
      end
      accept_none(8'hC3);
      check_none_frame(8'hC3, "post_rst");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("no_stale", {29'b0, none_tx, none_busy, none_rdy}, 32'b101);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
